agc_io_unit: RTL and testbench

//  AGC I/O channel block: 32 x 15-bit channel registers behind the Core's I/O read/write port.

---
 rtl/agc_io_if.sv | 25 ++
 rtl/agc_io_unit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_agc_io_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/agc_io_if.sv
// agc_io_if: Core-side I/O channel read/write port of the AGC I/O unit.
// The master is the Core; the slave is agc_io_unit.
interface agc_io_if;
    logic [4:0]  IO_read_sel;
    logic [14:0] IO_read_data;
    logic        IO_write_en;
    logic [4:0]  IO_write_sel;
    logic [14:0] IO_write_data;

    modport master (
        output IO_read_sel,
        input  IO_read_data,
        output IO_write_en,
        output IO_write_sel,
        output IO_write_data
    );

    modport slave (
        input  IO_read_sel,
        output IO_read_data,
        input  IO_write_en,
        input  IO_write_sel,
        input  IO_write_data
    );
endinterface

// File: rtl/agc_io_unit.sv
// agc_io_unit: 32 x 15-bit AGC I/O channels, Core writes streamed out as UART packets.
// Define IO_RX_EN to compile in the UART receiver that updates channels from rx.
module agc_io_unit #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TXQ_DEPTH    = 8
) (
    input  logic    clock,
    input  logic    reset,
    agc_io_if.slave io,
    output logic    tx,
    input  logic    rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(TXQ_DEPTH);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    logic [31:0][14:0] chan_q, chan_d;
    logic [TXQ_DEPTH-1:0][19:0] txq_q, txq_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic txq_empty, txq_full, txq_push, tx_pop;
    logic [19:0] txq_head;

    tx_state_e tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [1:0] tx_byte_q, tx_byte_d;
    logic tx_bit_end;
    logic [7:0] tx_cur_byte;

    logic rx_wr;
    logic [4:0] rx_wsel;
    logic [14:0] rx_wdata;

    assign io.IO_read_data = chan_q[io.IO_read_sel];

    // Core write is applied last so it wins over an RX update to the same channel.
    always_comb begin
        chan_d = chan_q;
        if (rx_wr) chan_d[rx_wsel] = rx_wdata;
        if (io.IO_write_en) chan_d[io.IO_write_sel] = io.IO_write_data;
    end

    assign txq_empty = (wr_ptr_q == rd_ptr_q);
    assign txq_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign txq_push  = io.IO_write_en && (!txq_full || tx_pop);
    assign txq_head  = txq_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        txq_d    = txq_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (txq_push) begin
            txq_d[wr_ptr_q[AW-1:0]] = {io.IO_write_sel, io.IO_write_data};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (tx_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    assign tx_bit_end = (tx_cnt_q == BIT_END);

    always_comb begin
        tx_cur_byte = {1'b0, txq_head[6:0]};
        unique case (tx_byte_q)
            2'd0:    tx_cur_byte = {1'b1, txq_head[14], 1'b0, txq_head[19:15]};
            2'd1:    tx_cur_byte = {1'b0, txq_head[13:7]};
            default: tx_cur_byte = {1'b0, txq_head[6:0]};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            chan_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
        end else begin
            chan_q     <= chan_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    always_ff @(posedge clock) begin
        txq_q <= txq_d;
    end

    // The packet stays at the queue head until its last stop bit, so it holds a slot.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d  = '0;
                tx_bit_d  = '0;
                tx_byte_d = '0;
                if (!txq_empty || io.IO_write_en) tx_state_d = TX_START;
            end
            TX_START: begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_byte_q == 2'd2) begin
                        tx_pop     = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_byte_d  = tx_byte_q + 2'd1;
                        tx_state_d = TX_START;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (tx_state_q)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = tx_cur_byte[tx_bit_q];
            default:  tx = 1'b1;
        endcase
    end

`ifdef IO_RX_EN
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {PK_HDR, PK_B1, PK_B2} pk_state_e;

    logic rx_s1_q, rx_s2_q;
    rx_state_e rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic rx_vld_q, rx_vld_d;
    logic rx_ferr_q, rx_ferr_d;
    pk_state_e pk_state_q, pk_state_d;
    logic [5:0] pk_hdr_q, pk_hdr_d;
    logic [6:0] pk_b1_q, pk_b1_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_vld_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            pk_state_q <= PK_HDR;
            pk_hdr_q   <= '0;
            pk_b1_q    <= '0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_vld_q   <= rx_vld_d;
            rx_ferr_q  <= rx_ferr_d;
            pk_state_q <= pk_state_d;
            pk_hdr_q   <= pk_hdr_d;
            pk_b1_q    <= pk_b1_d;
        end
    end

    // Bit timing: start confirmed at half bit, later samples fall mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_vld_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (!rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_BIT) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_vld_d   = rx_s2_q;
                    rx_ferr_d  = !rx_s2_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        pk_state_d = pk_state_q;
        pk_hdr_d   = pk_hdr_q;
        pk_b1_d    = pk_b1_q;
        rx_wr      = 1'b0;
        if (rx_ferr_q) begin
            pk_state_d = PK_HDR;
        end else if (rx_vld_q && rx_shift_q[7]) begin
            pk_hdr_d   = {rx_shift_q[6], rx_shift_q[4:0]};
            pk_state_d = PK_B1;
        end else if (rx_vld_q) begin
            unique case (pk_state_q)
                PK_B1: begin
                    pk_b1_d    = rx_shift_q[6:0];
                    pk_state_d = PK_B2;
                end
                PK_B2: begin
                    rx_wr      = 1'b1;
                    pk_state_d = PK_HDR;
                end
                default: pk_state_d = PK_HDR;
            endcase
        end
    end

    assign rx_wsel  = pk_hdr_q[4:0];
    assign rx_wdata = {pk_hdr_q[5], pk_b1_q, rx_shift_q[6:0]};
`else
    logic unused_rx;

    assign unused_rx = rx;
    assign rx_wr     = 1'b0;
    assign rx_wsel   = '0;
    assign rx_wdata  = '0;
`endif
endmodule

// File: tb/tb_agc_io_unit.sv
// tb_agc_io_unit: directed checks of channel access, TX packets, queue limit and RX.
// RX-dependent expectations follow the IO_RX_EN build option.
module tb_agc_io_unit;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic rx = 1'b1;

    agc_io_if io ();

    agc_io_unit #(.CLKS_PER_BIT(CPB), .TXQ_DEPTH(8)) dut (
        .clock (clk),
        .reset (rst),
        .io    (io),
        .tx    (tx),
        .rx    (rx)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // UART line monitor: decodes tx frames, sampling at bit centres on negedge.
    logic [7:0] mon_q[$];
    logic [7:0] mon_b;
    int mon_ferr = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (tx !== 1'b0) mon_ferr++;
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[j] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) mon_ferr++;
                mon_q.push_back(mon_b);
            end
        end
    end

    task automatic wait_bytes(input string tag, input int n, input int limit);
        int c = 0;
        while (mon_q.size() < n && c < limit) begin
            @(posedge clk);
            c++;
        end
        check(tag, mon_q.size(), n);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int j = 0; j < 8; j++) begin
            rx = b[j];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic write_ch(input logic [4:0] sel, input logic [14:0] d);
        io.IO_write_en   = 1'b1;
        io.IO_write_sel  = sel;
        io.IO_write_data = d;
        @(posedge clk);
        #1;
        io.IO_write_en = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] sel,
                            input logic [14:0] exp);
        io.IO_read_sel = sel;
        #1;
        check(tag, io.IO_read_data, exp);
    endtask

    int low_seen;
    int k;
    logic [7:0] got_b;

    initial begin
        io.IO_read_sel   = '0;
        io.IO_write_en   = 1'b0;
        io.IO_write_sel  = '0;
        io.IO_write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        for (int s = 0; s < 32; s++) read_chk("rst_chan", 5'(s), 15'h0000);
        low_seen = 0;
        repeat (10 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen++;
        end
        check("rst_tx_idle", low_seen, 0);
        @(posedge clk);
        #1;

        // Single write and its packet
        io.IO_read_sel   = 5'd5;
        io.IO_write_en   = 1'b1;
        io.IO_write_sel  = 5'd5;
        io.IO_write_data = 15'h7ABC;
        #1;
        check("rd_old_val", io.IO_read_data, 15'h0000);
        @(posedge clk);
        #1;
        io.IO_write_en = 1'b0;
        check("rd_new_val", io.IO_read_data, 15'h7ABC);
        check("tx_start_lat", tx, 1'b0);
        wait_bytes("pkt1_cnt", 3, 40 * CPB);
        got_b = (mon_q.size() > 0) ? mon_q.pop_front() : 8'h00;
        check("pkt1_b0", got_b, 8'hC5);
        got_b = (mon_q.size() > 0) ? mon_q.pop_front() : 8'h00;
        check("pkt1_b1", got_b, 8'h75);
        got_b = (mon_q.size() > 0) ? mon_q.pop_front() : 8'h00;
        check("pkt1_b2", got_b, 8'h3C);
        repeat (4 * CPB) @(posedge clk);
        #1;

        // RX packet for channel 13, not echoed
        send_byte(8'h8D);
        send_byte(8'h00);
        send_byte(8'h37);
        repeat (2 * CPB) @(posedge clk);
        #1;
`ifdef IO_RX_EN
        read_chk("rx_ch13", 5'd13, 15'h0037);
`else
        read_chk("rx_ch13", 5'd13, 15'h0000);
`endif
        check("rx_no_echo", mon_q.size(), 0);

        // Nine back-to-back writes into an 8-deep queue
        for (int i = 0; i < 9; i++) write_ch(5'(i), 15'(i));
        for (int i = 0; i < 9; i++) read_chk("burst_chan", 5'(i), 15'(i));
        wait_bytes("burst_cnt", 24, 400 * CPB);
        repeat (40 * CPB) @(posedge clk);
        #1;
        check("burst_no_extra", mon_q.size(), 24);
        for (int p = 0; p < 8; p++) begin
            got_b = (mon_q.size() > 0) ? mon_q.pop_front() : 8'h00;
            check("burst_b0", got_b, 8'h80 | 8'(p));
            got_b = (mon_q.size() > 0) ? mon_q.pop_front() : 8'h00;
            check("burst_b1", got_b, 8'h00);
            got_b = (mon_q.size() > 0) ? mon_q.pop_front() : 8'h00;
            check("burst_b2", got_b, 8'(p));
        end
        mon_q.delete();

        // Header restart mid-packet
        send_byte(8'h81);
        send_byte(8'h12);
        send_byte(8'h82);
        send_byte(8'h00);
        send_byte(8'h05);
        repeat (2 * CPB) @(posedge clk);
        #1;
        read_chk("hdr_restart_ch1", 5'd1, 15'h0001);
`ifdef IO_RX_EN
        read_chk("hdr_restart_ch2", 5'd2, 15'h0005);
`else
        read_chk("hdr_restart_ch2", 5'd2, 15'h0002);
`endif

`ifdef IO_RX_EN
        // Core write collides with an RX update of channel 3
        io.IO_read_sel = 5'd3;
        k = 0;
        fork
            begin
                send_byte(8'h83);
                send_byte(8'h44);
                send_byte(8'h22);
            end
            begin
                while (k < 40 * CPB) begin
                    @(posedge clk);
                    #1;
                    k++;
                    if (io.IO_read_data == 15'h2222) break;
                end
            end
        join
        check("coll_rx_seen", io.IO_read_data, 15'h2222);
        repeat (2 * CPB) @(posedge clk);
        #1;
        write_ch(5'd3, 15'h0000);
        repeat (2 * CPB) @(posedge clk);
        #1;
        mon_q.delete();
        fork
            begin
                send_byte(8'h83);
                send_byte(8'h44);
                send_byte(8'h22);
            end
            begin
                repeat (k - 1) @(posedge clk);
                #1;
                write_ch(5'd3, 15'h1111);
            end
        join
        repeat (2 * CPB) @(posedge clk);
        #1;
        read_chk("coll_core_wins", 5'd3, 15'h1111);
        repeat (40 * CPB) @(posedge clk);
        #1;
        mon_q.delete();
`endif
        check("tx_framing", mon_ferr, 0);

        // Reset in the middle of a frame
        write_ch(5'd9, 15'h0123);
        repeat (2 * CPB) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", tx, 1'b1);
        rst = 1'b0;
        read_chk("rst_mid_ch9", 5'd9, 15'h0000);
        low_seen = 0;
        repeat (10 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen++;
        end
        check("rst_mid_idle", low_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
